// File: rtl/init_ram_pkg.sv
// Shared widths, state encoding and the power-up fill pattern for the init_ram demo.
package init_ram_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [RAM_DATA_W-1:0] init_word(input logic [RAM_ADDR_W-1:0] addr);
        return {addr, ~addr};
    endfunction

endpackage

// File: rtl/init_ram_btn_edge.sv
// Two-flop synchronizer for the raw button followed by a one-clock rising-edge pulse.
module init_ram_btn_edge
    import init_ram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_out
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // sync3 only delays sync2, so a held button yields a single pulse
    assign pulse_out = sync2 & ~sync3;

endmodule

// File: rtl/init_ram_top.sv
// Fills the RAM with a fixed pattern after reset, then shows one word on the LEDs;
// each button press steps the read address, shown inverted on the anodes.
module init_ram_top
    import init_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    output logic [ADDR_W-1:0] an,
    output logic [DATA_W-1:0] Led
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              btn_pulse;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    init_ram_btn_edge u_btn_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn),
        .pulse_out(btn_pulse)
    );

    assign wr_en = (state == INIT);

    // RAM has no reset; INIT rewrites every word after each reset release
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= init_word(wr_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            wr_addr <= '0;
            rd_addr <= '0;
            Led     <= '0;
            an      <= '1;
        end else begin
            case (state)
                INIT: begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    Led     <= '0;
                    an      <= '1;
                    if (&wr_addr) begin
                        state <= READ;
                    end
                end
                READ: begin
                    Led <= mem[rd_addr];
                    an  <= ~rd_addr;
                    if (btn_pulse) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_init_ram_top.sv
// Directed bench for init_ram_top: fill sequence, button stepping, wrap and async reset.
module tb_init_ram_top;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [3:0] an;
    logic [7:0] Led;

    int passed;
    int total;

    init_ram_top dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .an   (an),
        .Led  (Led)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Release reset on a falling edge, then check 16 blank clocks and the first word.
    task automatic init_sequence(input bit press_in_init);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (press_in_init && i == 3) btn = 1'b1;
            if (press_in_init && i == 6) btn = 1'b0;
            check($sformatf("init_led_clk%0d", i), Led, 8'h00);
            check($sformatf("init_an_clk%0d", i), {4'h0, an}, 8'h0F);
        end
        @(negedge clk);
        check("first_led", Led, 8'h0F);
        check("first_an", {4'h0, an}, 8'h0F);
        repeat (5) @(negedge clk);
        check("stable_led", Led, 8'h0F);
        check("stable_an", {4'h0, an}, 8'h0F);
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        btn    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_led", Led, 8'h00);
        check("reset_an", {4'h0, an}, 8'h0F);

        init_sequence(1'b0);

        // exact four-clock latency, then no further change while held
        btn = 1'b1;
        repeat (3) @(negedge clk);
        check("latency3_led", Led, 8'h0F);
        @(negedge clk);
        check("latency4_led", Led, 8'h1E);
        check("latency4_an", {4'h0, an}, 8'h0E);
        repeat (20) @(negedge clk);
        check("held_led", Led, 8'h1E);
        check("held_an", {4'h0, an}, 8'h0E);
        btn = 1'b0;
        repeat (5) @(negedge clk);

        repeat (6) press();
        check("addr7_led", Led, 8'h78);
        check("addr7_an", {4'h0, an}, 8'h08);

        // asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_led", Led, 8'h00);
        check("async_rst_an", {4'h0, an}, 8'h0F);
        repeat (3) @(negedge clk);

        init_sequence(1'b1);

        repeat (5) press();
        check("addr5_led", Led, 8'h5A);
        check("addr5_an", {4'h0, an}, 8'h0A);

        repeat (10) press();
        check("addr15_led", Led, 8'hF0);
        check("addr15_an", {4'h0, an}, 8'h00);

        press();
        check("wrap_led", Led, 8'h0F);
        check("wrap_an", {4'h0, an}, 8'h0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/init_ram_top.md
Name: init_ram_top

Overview:
Board-level demo block. After reset it fills an on-chip RAM with a fixed pattern, then displays one RAM word at a time on the LEDs. Each press of the push-button advances the read address; the current address is shown on the anode outputs. It sits directly under the board top, with clk from the oscillator and btn from a push-button.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W = 16 words.
DATA_W, 8, RAM word width; must equal the Led width (8).

Ports:
clk  input  1  system clock; all flops are rising-edge.
rst_n  input  1  asynchronous active-low reset.
btn  input  1  raw push-button, active-high, asynchronous to clk.
an  output  4  active-low anode/address indicator.
Led  output  8  displayed RAM word.

Behaviour:
- Reset is asynchronous, assertion when rst_n=0. During reset:
  - state=INIT, wr_addr=0, rd_addr=0.
  - Led=8'h00, an=4'hF, button sync flops=0.
- Init pattern: word(a) = {a[3:0], ~a[3:0]}. Examples: addr0=8'h0F, addr1=8'h1E, addr5=8'h5A, addr15=8'hF0.
- State INIT:
  - One write per clock: mem[wr_addr] <= word(wr_addr); wr_addr increments.
  - After the write to address 15 (16th clock after reset release), go to READ.
  - While in INIT: Led=8'h00, an=4'hF, button edges are discarded.
- State READ:
  - Synchronous RAM read: Led <= mem[rd_addr] every clock, so Led reflects a new rd_addr 1 clock after it changes.
  - The first valid Led (8'h0F) appears 1 clock after entering READ, i.e. 17 clocks after reset release.
  - an = ~rd_addr (registered, same cycle as Led).
  - READ is terminal until reset.
- Button path:
  - btn goes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - Each rising edge produces exactly one 1-clock pulse, however long btn is held.
  - A pulse in READ increments rd_addr modulo 16 (15 -> 0 wrap).
  - Latency from btn rise to Led change: 2 sync clocks + 1 edge clock + 1 read clock = at most 4 clocks.
- No debouncing; the board is assumed clean or debounced upstream. Every synchronized rising edge counts.
- If a btn pulse is shorter than one clock period, it may be missed. Pulses of 2 or more clocks are always seen.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously). The RAM is fully rewritten after release.
- RAM contents are not reset, only rewritten by INIT. RAM is inferred as distributed or block RAM with a synchronous write and a registered read.

Decomposition:
- Package init_ram_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum {INIT, READ}, 1 bit.
  - Function init_word(addr) returning {addr, ~addr}.
- One sub-module: init_ram_btn_edge (clk, rst_n, btn_in, pulse_out), containing the 2-flop synchronizer plus the rising-edge detector.
- RAM, the INIT counter and the read path stay in init_ram_top.

Test Plan:
- Reset, then release rst_n; clk period 20 ns; no btn.
  - Led=8'h00 and an=4'hF for the first 16 clocks.
  - At clock 17: Led=8'h0F, an=4'hF (~0). Values then stay stable.
- After READ, pulse btn high for 3 clocks → within 4 clocks Led=8'h1E, an=4'hE. Led does not change again while btn is held for another 20 clocks.
- Press btn 5 times (each 3 clocks high, 5 clocks low) → Led=8'h5A, an=4'hA.
- Press btn 16 times from address 0 → returns to Led=8'h0F, an=4'hF (wrap 15→0). The 15th press shows 8'hF0, an=4'h0.
- Press btn during INIT (for example 50–100 ns after release) → ignored. READ starts at Led=8'h0F with rd_addr=0.
- Assert rst_n=0 mid-READ at address 7 → Led=8'h00, an=4'hF immediately (asynchronously). After release, the INIT/READ sequence of the first scenario repeats exactly.
